// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte/half/word load-store unit over a word-organised data memory.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two word accesses; otherwise they fault.
module lsu_mem_ctrl #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;

    state_t      state_q;
    logic        we_q, valid_q, fault_q, mwe_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [29:0] w0_q;
    logic [31:0] wdata_q, word0_q, rdata_q, a_q, wd_q;

    logic [29:0] a_w0;
    logic [1:0]  a_off;
    logic        a_cross, a_illegal, a_fault, a_sw;
    logic [31:0] cur0, lo_d, rdata_d;
    logic [4:0]  sh;

`ifdef LSU_MISALIGN_EN
    localparam int WIN = 64;
    logic        cross_q;
    logic [29:0] w1_q, a_w1;
    logic [31:0] word1_q, cur1;
`else
    localparam int WIN = 32;
`endif
    logic [WIN-1:0] win_d, mask_d, data_d, merged_d;

    assign a_w0      = req_addr[31:2];
    assign a_off     = req_addr[1:0];
    assign a_cross   = (req_funct3[1:0] == 2'b01 && a_off == 2'd3) || (req_funct3[1:0] == 2'b10 && a_off != 2'd0);
    assign a_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_we || req_funct3[1]));
    assign a_sw      = req_we && req_funct3 == 3'b010 && a_off == 2'd0;
    assign cur0      = (state_q == RD0) ? mem_RD : word0_q;

`ifdef LSU_MISALIGN_EN
    assign a_w1    = a_w0 + 30'd1;
    assign a_fault = a_illegal || ({2'b00, a_w0} >= DEPTH) || (a_cross && ({2'b00, a_w1} >= DEPTH));
    assign cur1    = (state_q == RD1) ? mem_RD : word1_q;
    assign win_d   = {cur1, cur0};
`else
    assign a_fault = a_illegal || ({2'b00, a_w0} >= DEPTH) || a_cross;
    assign win_d   = cur0;
`endif

    // Byte lanes are little-endian across the read window; both load extraction and store merge shift by off.
    assign sh       = {off_q, 3'b000};
    assign lo_d     = 32'(win_d >> sh);
    assign rdata_d  = f3_q[1] ? lo_d :
                      f3_q[0] ? {{16{lo_d[15] & ~f3_q[2]}}, lo_d[15:0]} :
                                {{24{lo_d[7] & ~f3_q[2]}}, lo_d[7:0]};
    assign mask_d   = WIN'(f3_q[1] ? 32'hFFFF_FFFF : f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    assign data_d   = WIN'(wdata_q) << sh;
    assign merged_d = (win_d & ~mask_d) | (data_d & mask_d);

    assign req_ready  = rst && state_q == IDLE;
    assign resp_valid = valid_q;
    assign resp_fault = fault_q;
    assign resp_rdata = rdata_q;
    assign mem_A      = a_q;
    assign mem_WD     = wd_q;
    assign mem_WE     = mwe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            w0_q    <= 30'd0;
            wdata_q <= 32'd0;
            word0_q <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            mwe_q   <= 1'b0;
            rdata_q <= 32'd0;
            a_q     <= 32'd0;
            wd_q    <= 32'd0;
`ifdef LSU_MISALIGN_EN
            cross_q <= 1'b0;
            w1_q    <= 30'd0;
            word1_q <= 32'd0;
`endif
        end else begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            mwe_q   <= 1'b0;
            rdata_q <= 32'd0;
            a_q     <= 32'd0;
            wd_q    <= 32'd0;
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    off_q   <= a_off;
                    w0_q    <= a_w0;
                    wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_EN
                    w1_q    <= a_w1;
                    cross_q <= a_cross;
`endif
                    if (a_fault) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        fault_q <= 1'b1;
                    end else if (a_sw) begin
                        state_q <= WR0;
                        a_q     <= {2'b00, a_w0};
                        wd_q    <= req_wdata;
                        mwe_q   <= 1'b1;
                    end else begin
                        state_q <= RD0;
                        a_q     <= {2'b00, a_w0};
                    end
                end
                RD0: begin
                    word0_q <= mem_RD;
`ifdef LSU_MISALIGN_EN
                    if (cross_q) begin
                        state_q <= RD1;
                        a_q     <= {2'b00, w1_q};
                    end else
`endif
                    if (we_q) begin
                        state_q <= WR0;
                        a_q     <= {2'b00, w0_q};
                        wd_q    <= merged_d[31:0];
                        mwe_q   <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        rdata_q <= rdata_d;
                    end
                end
`ifdef LSU_MISALIGN_EN
                RD1: begin
                    word1_q <= mem_RD;
                    if (we_q) begin
                        state_q <= WR0;
                        a_q     <= {2'b00, w0_q};
                        wd_q    <= merged_d[31:0];
                        mwe_q   <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        rdata_q <= rdata_d;
                    end
                end
                WR0: begin
                    if (cross_q) begin
                        state_q <= WR1;
                        a_q     <= {2'b00, w1_q};
                        wd_q    <= merged_d[63:32];
                        mwe_q   <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                WR1: begin
                    state_q <= DONE;
                    valid_q <= 1'b1;
                end
`else
                WR0: begin
                    state_q <= DONE;
                    valid_q <= 1'b1;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized and directed bench for lsu_mem_ctrl against a byte-level memory model.
module tb_lsu_mem_ctrl;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_fault, mem_WE;
    logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;

    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    logic [7:0]  refb [4*DEPTH] = '{default: 8'h0};
    logic        poke_en = 1'b0;
    int          poke_w = 0;
    logic [31:0] poke_v = 32'h0;
    logic [31:0] last_a;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    assign mem_RD = (mem_A < DEPTH) ? mem[mem_A[9:0]] : 32'h0;

    always @(posedge clk)
        if (mem_WE && mem_A < DEPTH) mem[mem_A[9:0]] <= mem_WD;
        else if (poke_en) mem[poke_w[9:0]] <= poke_v;

    function automatic int sz(input logic [2:0] f);
        return f[1] ? 4 : f[0] ? 2 : 1;
    endfunction

    function automatic bit m_cross(input logic [2:0] f, input logic [31:0] a);
        return int'(a[1:0]) + sz(f) > 4;
    endfunction

    function automatic bit m_fault(input logic we, input logic [2:0] f, input logic [31:0] a);
        longint unsigned w0, w1;
        bit legal;
        legal = we ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        w0 = longint'(a >> 2);
        w1 = (w0 + 1) % (64'd1 << 30);
        if (!legal || w0 >= DEPTH) return 1'b1;
`ifdef LSU_MISALIGN_EN
        return m_cross(f, a) && w1 >= DEPTH;
`else
        return m_cross(f, a);
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < sz(f); k++) v = v | (32'(refb[a + k]) << (8 * k));
        if (f == 3'b000) v = {{24{v[7]}}, v[7:0]};
        else if (f == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        poke_en = 1'b1;
        poke_w  = w;
        poke_v  = v;
        for (int k = 0; k < 4; k++) refb[4*w+k] = v[8*k +: 8];
        @(posedge clk);
        #1 poke_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat, output int wes);
        bit ef, cr, ok;
        logic [31:0] erd;
        int elat, ewes;
        int unsigned w0;
        ef   = m_fault(we, f, a);
        cr   = m_cross(f, a);
        w0   = a >> 2;
        erd  = (ef || we) ? 32'h0 : m_load(f, a);
        elat = ef ? 1 : !we ? (cr ? 3 : 2) : (f == 3'b010 && a[1:0] == 2'd0) ? 2 : cr ? 5 : 3;
        ewes = (ef || !we) ? 0 : cr ? 2 : 1;
        rd = 32'h0; flt = 1'b0; lat = 0; wes = 0;
        req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) if (req_ready) ok = 1'b1; else @(negedge clk);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: req_ready stayed %b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        lat = 1; ok = 1'b0; last_a = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) last_a = mem_A;
            if (mem_WE) wes++;
            if (resp_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        rd = resp_rdata; flt = resp_fault;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL resp_timeout: we=%0d f3=%0d addr=%h no resp_valid, required one", we, f, a); end
        n_cmp++;
        if (flt !== ef) begin n_bad++; $display("FAIL fault: we=%0d f3=%0d addr=%h got %b expected %b", we, f, a, flt, ef); end
        n_cmp++;
        if (rd !== erd) begin n_bad++; $display("FAIL rdata: we=%0d f3=%0d addr=%h got %h expected %h", we, f, a, rd, erd); end
        n_cmp++;
        if (lat != elat) begin n_bad++; $display("FAIL latency: we=%0d f3=%0d addr=%h got %0d expected %0d", we, f, a, lat, elat); end
        n_cmp++;
        if (wes != ewes) begin n_bad++; $display("FAIL we_pulses: we=%0d f3=%0d addr=%h got %0d expected %0d", we, f, a, wes, ewes); end
        if (we && !ef) for (int k = 0; k < sz(f); k++) refb[a + k] = wd[8*k +: 8];
        for (int unsigned w = w0; w <= w0 + 1; w++) if (w < DEPTH) begin
            n_cmp++;
            if (mem[w] !== ref_word(int'(w))) begin
                n_bad++;
                $display("FAIL mem_word: word %0d after we=%0d f3=%0d addr=%h got %h expected %h", w, we, f, a, mem[w], ref_word(int'(w)));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_done: valid/ready got %b%b expected 01", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({resp_valid, resp_fault, mem_WE, req_ready, resp_rdata, mem_A, mem_WD} !== 100'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: v=%b f=%b we=%b rdy=%b rd=%h a=%h wd=%h expected all 0",
                     resp_valid, resp_fault, mem_WE, req_ready, resp_rdata, mem_A, mem_WD);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
    endtask

    task automatic test_directed;
        logic [31:0] rd;
        logic flt;
        int lat, wes;
        logic [2:0]  tf [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] ta [3] = '{32'h73, 32'h72, 32'h71};
        logic [31:0] te [3] = '{32'h11, 32'h22, 32'h2233};
        do_req(1'b1, 3'b010, 32'h70, 32'hDEADBEEF, rd, flt, lat, wes);
        n_cmp++;
        if (lat != 2 || flt !== 1'b0 || last_a !== 32'h1C) begin
            n_bad++; $display("FAIL sw_aligned: lat=%0d flt=%b mem_A=%h expected 2 0 0000001c", lat, flt, last_a);
        end
        do_req(1'b0, 3'b010, 32'h70, 32'h0, rd, flt, lat, wes);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || lat != 2 || last_a !== 32'h1C) begin
            n_bad++; $display("FAIL lw_aligned: rd=%h lat=%0d mem_A=%h expected deadbeef 2 0000001c", rd, lat, last_a);
        end
        set_word(32'h1C, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, tf[i], ta[i], 32'h0, rd, flt, lat, wes);
            n_cmp++;
            if (rd !== te[i]) begin n_bad++; $display("FAIL subword_load%0d: got %h expected %h", i, rd, te[i]); end
        end
        set_word(32'h1C, 32'h80223344);
        do_req(1'b0, 3'b000, 32'h73, 32'h0, rd, flt, lat, wes);
        n_cmp++;
        if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_sign: got %h expected ffffff80", rd); end
        set_word(32'h1C, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h71, 32'hAB, rd, flt, lat, wes);
        n_cmp++;
        if (lat != 3 || wes != 1 || mem[32'h1C] !== 32'h1122AB44) begin
            n_bad++; $display("FAIL sb_rmw: lat=%0d wes=%0d word=%h expected 3 1 1122ab44", lat, wes, mem[32'h1C]);
        end
        set_word(32'h1D, 32'h55667788);
        set_word(32'h1C, 32'h11223344);
        do_req(1'b0, 3'b010, 32'h72, 32'h0, rd, flt, lat, wes);
        n_cmp++;
`ifdef LSU_MISALIGN_EN
        if (rd !== 32'h77881122 || lat != 3 || flt !== 1'b0) begin
            n_bad++; $display("FAIL lw_cross: rd=%h lat=%0d flt=%b expected 77881122 3 0", rd, lat, flt);
        end
`else
        if (rd !== 32'h0 || lat != 1 || flt !== 1'b1) begin
            n_bad++; $display("FAIL lw_cross: rd=%h lat=%0d flt=%b expected 0 1 1", rd, lat, flt);
        end
`endif
        do_req(1'b1, 3'b010, 32'h73, 32'hAABBCCDD, rd, flt, lat, wes);
        n_cmp++;
`ifdef LSU_MISALIGN_EN
        if (lat != 5 || wes != 2 || mem[32'h1C] !== 32'hDD223344 || mem[32'h1D] !== 32'h55AABBCC) begin
            n_bad++; $display("FAIL sw_cross: lat=%0d wes=%0d w0=%h w1=%h expected 5 2 dd223344 55aabbcc",
                              lat, wes, mem[32'h1C], mem[32'h1D]);
        end
`else
        if (lat != 1 || wes != 0 || flt !== 1'b1 || mem[32'h1C] !== 32'h11223344 || mem[32'h1D] !== 32'h55667788) begin
            n_bad++; $display("FAIL sw_cross: lat=%0d wes=%0d flt=%b w0=%h w1=%h expected 1 0 1 11223344 55667788",
                              lat, wes, flt, mem[32'h1C], mem[32'h1D]);
        end
`endif
    endtask

    task automatic test_faults;
        logic [31:0] rd;
        logic flt;
        int lat, wes;
        logic        fw [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  ff [7] = '{3'b011, 3'b110, 3'b100, 3'b010, 3'b001, 3'b010, 3'b010};
        logic [31:0] fa [7] = '{32'h10, 32'h10, 32'h10, 32'(4*DEPTH), 32'(4*DEPTH-1), 32'hFFFFFFFC, 32'hFFFFFFFD};
        for (int i = 0; i < 7; i++) begin
            do_req(fw[i], ff[i], fa[i], 32'h12345678, rd, flt, lat, wes);
            n_cmp++;
            if (flt !== 1'b1 || rd !== 32'h0 || wes != 0 || lat != 1) begin
                n_bad++; $display("FAIL fault_case%0d: flt=%b rd=%h wes=%0d lat=%0d expected 1 0 0 1", i, flt, rd, wes, lat);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a;
        logic flt;
        int lat, wes, r;
        for (int w = 0; w < 64; w++) set_word(w, $urandom);
        for (int w = DEPTH - 4; w < DEPTH; w++) set_word(w, $urandom);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            a = (r < 6) ? 32'($urandom_range(0, 255)) : (r < 9) ? 32'(4*DEPTH - 16 + $urandom_range(0, 19)) : $urandom;
            do_req(1'($urandom), 3'($urandom), a, $urandom, rd, flt, lat, wes);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_ld;
        bit ok;
        set_word(32'h10, 32'hCAFEF00D);
        set_word(32'h11, 32'h01020304);
        exp_ld = m_load(3'b010, 32'h40);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h9ABCDEF0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok || resp_rdata !== exp_ld || resp_fault !== 1'b0) begin
            n_bad++; $display("FAIL b2b_load: seen=%b rd=%h expected 1 %h", ok, resp_rdata, exp_ld);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready: got %b expected 1", req_ready); end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0 || mem_WE !== 1'b1 || mem_A !== 32'h11) begin
            n_bad++; $display("FAIL b2b_accept: rdy=%b we=%b a=%h expected 0 1 00000011", req_ready, mem_WE, mem_A);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) refb[32'h44 + k] = req_wdata[8*k +: 8];
        n_cmp++;
        if (mem[32'h11] !== ref_word(32'h11) || mem[32'h10] !== ref_word(32'h10)) begin
            n_bad++; $display("FAIL b2b_store: w10=%h w11=%h expected %h %h", mem[32'h10], mem[32'h11], ref_word(32'h10), ref_word(32'h11));
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        set_word(32'h1C, 32'h11223344);
        set_word(32'h1D, 32'h55667788);
`ifdef LSU_MISALIGN_EN
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h73; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_WE !== 1'b1 || mem_A !== 32'h1D) begin n_bad++; $display("FAIL mid_wr1: we=%b a=%h expected 1 0000001d", mem_WE, mem_A); end
        rst = 1'b0;
        refb[32'h73] = 8'hDD;
`else
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h71; req_wdata = 32'hAB; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_WE !== 1'b1 || mem_A !== 32'h1C) begin n_bad++; $display("FAIL mid_wr0: we=%b a=%h expected 1 0000001c", mem_WE, mem_A); end
        rst = 1'b0;
`endif
        #1;
        n_cmp++;
        if ({resp_valid, resp_fault, mem_WE, req_ready, resp_rdata, mem_A, mem_WD} !== 100'h0) begin
            n_bad++; $display("FAIL mid_reset_outputs: v=%b we=%b rdy=%b a=%h wd=%h expected all 0", resp_valid, mem_WE, req_ready, mem_A, mem_WD);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL mid_release: resp_valid/req_ready got wrong values, required 0/1 after release"); end
        n_cmp++;
        if (mem[32'h1C] !== ref_word(32'h1C) || mem[32'h1D] !== ref_word(32'h1D)) begin
            n_bad++; $display("FAIL mid_memory: w0=%h w1=%h expected %h %h", mem[32'h1C], mem[32'h1D], ref_word(32'h1C), ref_word(32'h1D));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_directed;
        test_faults;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
